// File: rtl/disp_pkg.sv
// Shared types and constants for the multiplexed seven-segment display controller.
package disp_pkg;

    typedef logic [1:0] digit_idx_t;

    localparam int         NUM_DIGITS       = 4;
    localparam logic [3:0] AN_OFF           = 4'b1111;

    localparam int         SCAN_DIV_DEF     = 4096;
    localparam int         DEB_CYCLES_DEF   = 8192;
    localparam int         BLINK_ROUNDS_DEF = 64;

    // Active-low one-cold enable for a single digit.
    function automatic logic [3:0] an_select(input digit_idx_t idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer, stable-level counter and a
// single-cycle pulse on each accepted press.
module btn_debounce
    import disp_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
    input  logic Clk,
    input  logic rst,
    input  logic raw,
    output logic pulse
);

    localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

    logic          sync0;
    logic          sync1;
    logic          level;
    logic [CW-1:0] cnt;
    logic          flip;

    assign flip  = (sync1 != level) && (cnt == CW'(DEB_CYCLES - 1));
    // Pulse coincides with the edge on which the debounced level rises.
    assign pulse = flip && !level;

    always_ff @(posedge Clk) begin
        if (rst) begin
            sync0 <= 1'b0;
            sync1 <= 1'b0;
            level <= 1'b0;
            cnt   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            sync0 <= raw;
            sync1 <= sync0;
            if (sync1 == level) begin
                cnt <= '0;
            end else if (flip) begin
                level <= ~level;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/disp_scan_ctrl.sv
// Four-digit seven-segment scan controller with edit cursor, digit load and
// cursor-digit blinking.
module disp_scan_ctrl
    import disp_pkg::*;
#(
    parameter int SCAN_DIV     = SCAN_DIV_DEF,
    parameter int DEB_CYCLES   = DEB_CYCLES_DEF,
    parameter int BLINK_ROUNDS = BLINK_ROUNDS_DEF
) (
    input  logic       Clk,
    input  logic       rst,
    input  logic       btn_next,
    input  logic       btn_load,
    input  logic [3:0] sw,
    input  logic       blink_en,
    output logic [3:0] nibble,
    output logic [3:0] an,
    output logic [1:0] cursor
);

    localparam int TW = $clog2(SCAN_DIV);
    localparam int RW = (BLINK_ROUNDS > 1) ? $clog2(BLINK_ROUNDS) : 1;

    logic [3:0]    digit [NUM_DIGITS];
    digit_idx_t    idx;
    logic [TW-1:0] timer;
    logic [RW-1:0] round_cnt;
    logic          phase;
    logic          next_p;
    logic          load_p;
    logic [3:0]    an_next;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_next (
        .Clk   (Clk),
        .rst   (rst),
        .raw   (btn_next),
        .pulse (next_p)
    );

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_load (
        .Clk   (Clk),
        .rst   (rst),
        .raw   (btn_load),
        .pulse (load_p)
    );

    always_comb begin
        // NOTE: default first so no path leaves an_next unassigned (no latch).
        an_next = an_select(idx);
        if (blink_en && !phase && (idx == digit_idx_t'(cursor))) begin
            an_next = AN_OFF;
        end
    end

    always_ff @(posedge Clk) begin
        if (rst) begin
            // NOTE: the digit store is cleared on reset, so it must stay in flops.
            for (int i = 0; i < NUM_DIGITS; i++) begin
                digit[i] <= 4'h0;
            end
            idx       <= '0;
            timer     <= '0;
            round_cnt <= '0;
            phase     <= 1'b1;
            cursor    <= '0;
            nibble    <= 4'h0;
            an        <= AN_OFF;
        end else begin
            if (timer == TW'(SCAN_DIV - 1)) begin
                timer <= '0;
                idx   <= idx + digit_idx_t'(1);
                if (idx == digit_idx_t'(NUM_DIGITS - 1)) begin
                    if (round_cnt == RW'(BLINK_ROUNDS - 1)) begin
                        round_cnt <= '0;
                        phase     <= ~phase;
                    end else begin
                        round_cnt <= round_cnt + RW'(1);
                    end
                end
            end else begin
                timer <= timer + TW'(1);
            end

            // A simultaneous load writes at the pre-increment cursor.
            if (load_p) begin
                digit[cursor] <= sw;
            end
            if (next_p) begin
                cursor <= cursor + 2'd1;
            end

            nibble <= digit[idx];
            an     <= an_next;
        end
    end

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Directed self-checking bench for disp_scan_ctrl with SCAN_DIV=4,
// DEB_CYCLES=3, BLINK_ROUNDS=2.
module tb_disp_scan_ctrl;

    logic       Clk;
    logic       rst;
    logic       btn_next;
    logic       btn_load;
    logic [3:0] sw;
    logic       blink_en;
    logic [3:0] nibble;
    logic [3:0] an;
    logic [1:0] cursor;

    int total;
    int passed;
    int k;      // posedges since reset release

    disp_scan_ctrl #(
        .SCAN_DIV     (4),
        .DEB_CYCLES   (3),
        .BLINK_ROUNDS (2)
    ) dut (
        .Clk      (Clk),
        .rst      (rst),
        .btn_next (btn_next),
        .btn_load (btn_load),
        .sw       (sw),
        .blink_en (blink_en),
        .nibble   (nibble),
        .an       (an),
        .cursor   (cursor)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge Clk);
        #1;
        k++;
    endtask

    // Edge kk after release shows slot (kk-1)/4; blink-off rounds are 2,3,6,7,...
    function automatic int slot_digit(input int kk);
        return ((kk - 1) / 4) % 4;
    endfunction

    function automatic logic [3:0] exp_an(input int kk, input int cur, input bit blink);
        int d;
        bit off;
        d   = slot_digit(kk);
        off = (((kk - 1) / 32) % 2) == 1;
        if (blink && off && d == cur) return 4'b1111;
        return ~(4'b0001 << d);
    endfunction

    function automatic logic [3:0] exp_nib(input int kk, input logic [15:0] digs);
        return digs[slot_digit(kk)*4 +: 4];
    endfunction

    task automatic press(input bit nxt, input bit ld, input int hold);
        if (nxt) btn_next = 1'b1;
        if (ld)  btn_load = 1'b1;
        repeat (hold) tick();
        btn_next = 1'b0;
        btn_load = 1'b0;
        repeat (8) tick();
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        k   = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        total++; if (an !== 4'b1111) $display("FAIL reset_an: got %b expected 1111", an); else passed++;
        total++; if (nibble !== 4'h0) $display("FAIL reset_nibble: got %h expected 0", nibble); else passed++;
        total++; if (cursor !== 2'd0) $display("FAIL reset_cursor: got %0d expected 0", cursor); else passed++;
        rst = 1'b0;
        k   = 0;
        for (int i = 0; i < 32; i++) begin
            tick();
            total++;
            if (an !== exp_an(k, 0, 1'b0))
                $display("FAIL reset_scan_an k=%0d: got %b expected %b", k, an, exp_an(k, 0, 1'b0));
            else passed++;
            total++;
            if (nibble !== 4'h0)
                $display("FAIL reset_scan_nibble k=%0d: got %h expected 0", k, nibble);
            else passed++;
        end
    endtask

    task automatic test_load_next();
        sw = 4'hA;
        press(1'b0, 1'b1, 6);
        press(1'b1, 1'b0, 6);
        sw = 4'h5;
        press(1'b0, 1'b1, 6);
        total++; if (cursor !== 2'd1) $display("FAIL load_cursor: got %0d expected 1", cursor); else passed++;
        for (int i = 0; i < 16; i++) begin
            tick();
            total++;
            if (an !== exp_an(k, 1, 1'b0))
                $display("FAIL load_an k=%0d: got %b expected %b", k, an, exp_an(k, 1, 1'b0));
            else passed++;
            total++;
            if (nibble !== exp_nib(k, 16'h005A))
                $display("FAIL load_nibble k=%0d: got %h expected %h", k, nibble, exp_nib(k, 16'h005A));
            else passed++;
        end
    endtask

    task automatic test_debounce();
        logic [1:0] want;
        btn_next = 1'b1;
        tick();
        tick();
        btn_next = 1'b0;
        repeat (8) tick();
        total++; if (cursor !== 2'd1) $display("FAIL glitch_cursor: got %0d expected 1", cursor); else passed++;
        btn_next = 1'b1;
        for (int n = 1; n <= 10; n++) begin
            tick();
            want = (n >= 5) ? 2'd2 : 2'd1;
            total++;
            if (cursor !== want)
                $display("FAIL press_latency n=%0d: got %0d expected %0d", n, cursor, want);
            else passed++;
        end
        btn_next = 1'b0;
        repeat (8) tick();
        total++; if (cursor !== 2'd2) $display("FAIL release_cursor: got %0d expected 2", cursor); else passed++;
    endtask

    task automatic test_wrap_simultaneous();
        apply_reset();
        repeat (3) press(1'b1, 1'b0, 6);
        total++; if (cursor !== 2'd3) $display("FAIL three_next_cursor: got %0d expected 3", cursor); else passed++;
        sw = 4'hF;
        press(1'b1, 1'b1, 6);
        total++; if (cursor !== 2'd0) $display("FAIL wrap_cursor: got %0d expected 0", cursor); else passed++;
        for (int i = 0; i < 16; i++) begin
            tick();
            total++;
            if (an !== exp_an(k, 0, 1'b0))
                $display("FAIL wrap_an k=%0d: got %b expected %b", k, an, exp_an(k, 0, 1'b0));
            else passed++;
            total++;
            if (nibble !== exp_nib(k, 16'hF000))
                $display("FAIL wrap_nibble k=%0d: got %h expected %h", k, nibble, exp_nib(k, 16'hF000));
            else passed++;
        end
    endtask

    task automatic test_blink();
        apply_reset();
        blink_en = 1'b1;
        press(1'b1, 1'b0, 6);
        press(1'b1, 1'b0, 6);
        total++; if (cursor !== 2'd2) $display("FAIL blink_cursor: got %0d expected 2", cursor); else passed++;
        while (k < 32) tick();
        for (int i = 0; i < 64; i++) begin
            tick();
            total++;
            if (an !== exp_an(k, 2, 1'b1))
                $display("FAIL blink_an k=%0d: got %b expected %b", k, an, exp_an(k, 2, 1'b1));
            else passed++;
            total++;
            if (nibble !== 4'h0)
                $display("FAIL blink_nibble k=%0d: got %h expected 0", k, nibble);
            else passed++;
        end
        // Off phase again, but with blinking disabled nothing may blank.
        blink_en = 1'b0;
        for (int i = 0; i < 32; i++) begin
            tick();
            total++;
            if (an !== exp_an(k, 2, 1'b0))
                $display("FAIL noblink_an k=%0d: got %b expected %b", k, an, exp_an(k, 2, 1'b0));
            else passed++;
        end
    endtask

    task automatic test_mid_reset();
        sw = 4'h7;
        press(1'b0, 1'b1, 6);
        press(1'b1, 1'b0, 6);
        sw = 4'h3;
        press(1'b0, 1'b1, 6);
        repeat (3) press(1'b1, 1'b0, 6);
        for (int i = 0; i < 16; i++) begin
            tick();
            total++;
            if (nibble !== exp_nib(k, 16'h3700))
                $display("FAIL pre_reset_nibble k=%0d: got %h expected %h", k, nibble, exp_nib(k, 16'h3700));
            else passed++;
        end
        total++; if (cursor !== 2'd2) $display("FAIL pre_reset_cursor: got %0d expected 2", cursor); else passed++;
        rst = 1'b1;
        tick();
        total++; if (an !== 4'b1111) $display("FAIL mid_reset_an: got %b expected 1111", an); else passed++;
        total++; if (nibble !== 4'h0) $display("FAIL mid_reset_nibble: got %h expected 0", nibble); else passed++;
        total++; if (cursor !== 2'd0) $display("FAIL mid_reset_cursor: got %0d expected 0", cursor); else passed++;
        rst = 1'b0;
        k   = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            total++;
            if (an !== exp_an(k, 0, 1'b0))
                $display("FAIL restart_an k=%0d: got %b expected %b", k, an, exp_an(k, 0, 1'b0));
            else passed++;
            total++;
            if (nibble !== 4'h0)
                $display("FAIL restart_nibble k=%0d: got %h expected 0", k, nibble);
            else passed++;
        end
    endtask

    initial begin
        total    = 0;
        passed   = 0;
        k        = 0;
        rst      = 1'b1;
        btn_next = 1'b0;
        btn_load = 1'b0;
        sw       = 4'h0;
        blink_en = 1'b0;

        test_reset();
        test_load_next();
        test_debounce();
        test_wrap_simultaneous();
        test_blink();
        test_mid_reset();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
